tl_ul_ram_slave: RTL and testbench
==================================

Name: tl_ul_ram_slave

Overview:
- TileLink-UL slave endpoint: a single-ported word RAM that consumes A-channel requests and returns D-channel responses.
- Sits directly downstream of the master/slave bridge. Its a_* inputs and d_ready are driven by the bridge's slave_a_* and slave_d_ready. Its d_* outputs and a_ready feed the bridge's slave_d_* and slave_a_ready.
- Serves Get, PutFullData and PutPartialData with one-cycle response latency, full throughput, and error signalling.

Parameters:
- TL_AW, 32, address width
- TL_DW, 32, data width (power of 2, ≥8)
- TL_AIW, 8, source ID width
- TL_DIW, 1, sink ID width
- TL_DBW, TL_DW>>3, byte lanes per word
- TL_SZW, $clog2($clog2(TL_DBW)+1), size field width
- DEPTH, 256, RAM depth in words (power of 2)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- a_valid  in  1  request valid
- a_ready  out  1  request accepted when high with a_valid
- a_opcode  in  3  0 PutFullData, 1 PutPartialData, 4 Get
- a_param  in  3  must be 0
- a_size  in  TL_SZW  log2 of transfer bytes
- a_source  in  TL_AIW  requester ID
- a_address  in  TL_AW  byte address
- a_mask  in  TL_DBW  byte-lane enables
- a_data  in  TL_DW  write data
- d_valid  out  1  response valid
- d_ready  in  1  response consumed
- d_opcode  out  3  0 AccessAck, 1 AccessAckData
- d_param  out  3  always 0
- d_size  out  TL_SZW  echo of a_size
- d_source  out  TL_AIW  echo of a_source
- d_sink  out  TL_DIW  always 0
- d_data  out  TL_DW  read data; 0 for acks and errors
- d_error  out  1  request failed

Behaviour:
- Reset (async assert, sync release): d_valid=0, d_opcode/d_size/d_source/d_data/d_error=0. a_ready is 0 while rst is high. RAM contents are not cleared.
- Reset asserted mid-transaction: the pending response is dropped and d_valid falls immediately. A write already accepted stays committed.
- Acceptance: a_ready = !d_valid | d_ready (one-entry response register). An A beat is accepted when a_valid & a_ready.
- Latency: a request accepted in cycle N produces d_valid in cycle N+1. Back-to-back accepts give 1 response/cycle while d_ready=1.
- Back-pressure: while d_valid & !d_ready, all d_* outputs hold stable and a_ready=0.
- Word index: a_address[log2(TL_DBW)+log2(DEPTH)-1 : log2(TL_DBW)].
- Expected lane mask: 2^(2^size)-1 bits starting at lane a_address[log2(TL_DBW)-1:0].
- Error conditions; any one sets d_error=1 and suppresses the RAM write:
  - opcode not in {0,1,4}
  - a_param≠0
  - a_size > log2(TL_DBW)
  - address not aligned to 2^size
  - PutFullData with a_mask ≠ expected mask
  - PutPartialData or Get with a_mask containing lanes outside the expected mask
- Error response: d_opcode = 1 for Get, 0 otherwise; d_data=0.
- Write commit: on the accept edge, bytes with a_mask set are written. A Get accepted in the following cycle to the same word returns the new data (no hazard).
- Get: d_data = full RAM word, all lanes, regardless of mask.
- Response fields: d_param=0, d_sink=0, d_size=a_size, d_source=a_source, captured at accept.

Optional Feature:
- TL_RAM_BOUNDS_CHECK_EN defined: a_address ≥ DEPTH*TL_DBW is an error: no write, d_error=1.
- Not defined: upper address bits are ignored and the word index wraps modulo DEPTH with no error.

Test Plan:
- Reset mid-response: rst pulse while d_valid=1 and d_ready=0 → d_valid=0 in the same cycle; a later Get of the written word returns the committed data.
- PutFull 0x11223344 @0x10, size 2, mask 0xF, source 0x5A → next cycle AccessAck, d_source=0x5A, d_error=0. Get @0x10 → AccessAckData, d_data=0x11223344.
- PutPartial @0x12, size 1, mask 0xC, data 0xBEEF0000 → Get @0x10 returns 0xBEEF3344.
- Misaligned Get @0x11, size 1 → d_opcode=1, d_error=1, d_data=0. Opcode 2 → d_error=1, no RAM change.
- Back-pressure: d_ready=0 for 3 cycles with a_valid held → a_ready=0 and d_* stable; on d_ready=1, throughput is 1 response/cycle over 8 back-to-back Gets.
- Address 0x400 (DEPTH=256): with TL_RAM_BOUNDS_CHECK_EN → d_error=1; without it → aliases word 0 with no error.

Source files
------------

// File: rtl/tl_ul_ram_slave.sv
// TileLink-UL slave endpoint over a single-ported word RAM with a one-entry response register.
// Optional: define TL_RAM_BOUNDS_CHECK_EN to flag byte addresses >= DEPTH*TL_DBW as errors.
module tl_ul_ram_slave #(
  parameter int TL_AW  = 32,
  parameter int TL_DW  = 32,
  parameter int TL_AIW = 8,
  parameter int TL_DIW = 1,
  parameter int TL_DBW = TL_DW >> 3,
  parameter int TL_SZW = $clog2($clog2(TL_DBW) + 1),
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [2:0]        a_opcode,
  input  logic [2:0]        a_param,
  input  logic [TL_SZW-1:0] a_size,
  input  logic [TL_AIW-1:0] a_source,
  input  logic [TL_AW-1:0]  a_address,
  input  logic [TL_DBW-1:0] a_mask,
  input  logic [TL_DW-1:0]  a_data,
  output logic              d_valid,
  input  logic              d_ready,
  output logic [2:0]        d_opcode,
  output logic [2:0]        d_param,
  output logic [TL_SZW-1:0] d_size,
  output logic [TL_AIW-1:0] d_source,
  output logic [TL_DIW-1:0] d_sink,
  output logic [TL_DW-1:0]  d_data,
  output logic              d_error
);

  localparam int unsigned OFFW   = $clog2(TL_DBW);
  localparam int unsigned IDXW   = $clog2(DEPTH);
  localparam int unsigned OFFW_1 = (OFFW > 0) ? OFFW : 1;
  localparam logic [TL_SZW-1:0] MAX_SIZE = TL_SZW'(OFFW);

  typedef enum logic [2:0] {
    PUT_FULL    = 3'd0,
    PUT_PARTIAL = 3'd1,
    GET         = 3'd4
  } a_op_e;

  typedef enum logic [2:0] {
    ACCESS_ACK      = 3'd0,
    ACCESS_ACK_DATA = 3'd1
  } d_op_e;

  logic [TL_DW-1:0] mem_q [DEPTH];

  logic              d_valid_q,  d_valid_d;
  d_op_e             d_opcode_q, d_opcode_d;
  logic [TL_SZW-1:0] d_size_q,   d_size_d;
  logic [TL_AIW-1:0] d_source_q, d_source_d;
  logic [TL_DW-1:0]  d_data_q,   d_data_d;
  logic              d_error_q,  d_error_d;

  logic              accept;
  logic [IDXW-1:0]   word_idx;
  logic [OFFW_1-1:0] lane_off;
  logic [TL_DBW-1:0] exp_mask;
  logic              is_get, is_put_full, is_put_partial, op_ok;
  logic              size_err, align_err, mask_err, bound_err, req_err;
  logic              wr_en;
  logic              unused_addr_hi;

  assign a_ready  = ~rst & (~d_valid_q | d_ready);
  assign accept   = a_valid & a_ready;
  assign word_idx = a_address[OFFW +: IDXW];
  assign lane_off = (OFFW == 0) ? '0 : a_address[OFFW_1-1:0];

  assign is_get         = (a_opcode == GET);
  assign is_put_full    = (a_opcode == PUT_FULL);
  assign is_put_partial = (a_opcode == PUT_PARTIAL);
  assign op_ok          = is_get | is_put_full | is_put_partial;

  // Lanes sharing the address's size-aligned group form the expected mask;
  // a misaligned address is already an error, so alignment-down is harmless.
  always_comb begin
    exp_mask  = '0;
    align_err = 1'b0;
    for (int unsigned l = 0; l < TL_DBW; l++) begin
      exp_mask[l] = ((l >> a_size) == (32'(lane_off) >> a_size));
    end
    for (int unsigned b = 0; b < OFFW; b++) begin
      if ((b < 32'(a_size)) && a_address[b]) align_err = 1'b1;
    end
  end

  assign size_err = (a_size > MAX_SIZE);
  assign mask_err = is_put_full ? (a_mask != exp_mask) : |(a_mask & ~exp_mask);

`ifdef TL_RAM_BOUNDS_CHECK_EN
  assign bound_err = |a_address[TL_AW-1:OFFW+IDXW];
`else
  assign bound_err = 1'b0;
`endif
  assign unused_addr_hi = ^a_address[TL_AW-1:OFFW+IDXW];

  assign req_err = ~op_ok | (a_param != 3'd0) | size_err | align_err | mask_err | bound_err;
  assign wr_en   = accept & ~req_err & (is_put_full | is_put_partial);

  always_comb begin
    d_valid_d  = d_valid_q;
    d_opcode_d = d_opcode_q;
    d_size_d   = d_size_q;
    d_source_d = d_source_q;
    d_data_d   = d_data_q;
    d_error_d  = d_error_q;
    if (accept) begin
      d_valid_d  = 1'b1;
      d_opcode_d = is_get ? ACCESS_ACK_DATA : ACCESS_ACK;
      d_size_d   = a_size;
      d_source_d = a_source;
      d_error_d  = req_err;
      d_data_d   = (is_get & ~req_err) ? mem_q[word_idx] : '0;
    end else if (d_ready) begin
      d_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_valid_q  <= 1'b0;
      d_opcode_q <= ACCESS_ACK;
      d_size_q   <= '0;
      d_source_q <= '0;
      d_data_q   <= '0;
      d_error_q  <= 1'b0;
    end else begin
      d_valid_q  <= d_valid_d;
      d_opcode_q <= d_opcode_d;
      d_size_q   <= d_size_d;
      d_source_q <= d_source_d;
      d_data_q   <= d_data_d;
      d_error_q  <= d_error_d;
    end
  end

  // RAM is deliberately outside the reset domain so accepted writes survive a reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned b = 0; b < TL_DBW; b++) begin
        if (a_mask[b]) mem_q[word_idx][8*b +: 8] <= a_data[8*b +: 8];
      end
    end
  end

  assign d_valid  = d_valid_q;
  assign d_opcode = d_opcode_q;
  assign d_param  = '0;
  assign d_size   = d_size_q;
  assign d_source = d_source_q;
  assign d_sink   = '0;
  assign d_data   = d_data_q;
  assign d_error  = d_error_q;

endmodule

// File: tb/tb_tl_ul_ram_slave.sv
// Randomised bench for tl_ul_ram_slave: byte-array reference model, per-cycle compare, directed literals.
module tb_tl_ul_ram_slave;

  localparam int TL_AW  = 32;
  localparam int TL_DW  = 32;
  localparam int TL_AIW = 8;
  localparam int TL_DIW = 1;
  localparam int TL_DBW = 4;
  localparam int TL_SZW = 2;
  localparam int DEPTH  = 256;
  localparam int unsigned NBYTES = DEPTH * TL_DBW;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              a_valid = 1'b0;
  logic              a_ready;
  logic [2:0]        a_opcode = '0;
  logic [2:0]        a_param = '0;
  logic [TL_SZW-1:0] a_size = '0;
  logic [TL_AIW-1:0] a_source = '0;
  logic [TL_AW-1:0]  a_address = '0;
  logic [TL_DBW-1:0] a_mask = '0;
  logic [TL_DW-1:0]  a_data = '0;
  logic              d_valid;
  logic              d_ready = 1'b1;
  logic [2:0]        d_opcode;
  logic [2:0]        d_param;
  logic [TL_SZW-1:0] d_size;
  logic [TL_AIW-1:0] d_source;
  logic [TL_DIW-1:0] d_sink;
  logic [TL_DW-1:0]  d_data;
  logic              d_error;

  always #5 clk = ~clk;

  tl_ul_ram_slave #(
    .TL_AW(TL_AW), .TL_DW(TL_DW), .TL_AIW(TL_AIW), .TL_DIW(TL_DIW),
    .TL_DBW(TL_DBW), .TL_SZW(TL_SZW), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
    .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
    .a_data(a_data),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
    .d_size(d_size), .d_source(d_source), .d_sink(d_sink), .d_data(d_data),
    .d_error(d_error)
  );

  int tests = 0;
  int fails = 0;
  int consumed = 0;
  bit check_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: byte-addressed memory plus the single pending response.
  logic [7:0]  mbytes [NBYTES];
  logic        m_dvalid = 1'b0;
  logic [2:0]  m_op = '0;
  logic [1:0]  m_size = '0;
  logic [7:0]  m_src = '0;
  logic [31:0] m_data = '0;
  logic        m_err = 1'b0;

  task automatic model_accept();
    int unsigned addr = a_address;
    int unsigned nb, off, emask, base;
    bit err = 1'b0;
    bit get = (a_opcode == 3'd4);
    bit put = (a_opcode == 3'd0) || (a_opcode == 3'd1);
    if (!get && !put) err = 1'b1;
    if (a_param != 3'd0) err = 1'b1;
    if (a_size > 2'd2) err = 1'b1;
    nb = 1 << a_size;
    if ((addr % nb) != 0) err = 1'b1;
    off = addr % TL_DBW;
    emask = ((1 << nb) - 1) << off;
    if (a_opcode == 3'd0 && 32'(a_mask) != emask) err = 1'b1;
    if ((a_opcode == 3'd1 || get) && ((32'(a_mask) & ~emask) != 0)) err = 1'b1;
`ifdef TL_RAM_BOUNDS_CHECK_EN
    if (addr >= NBYTES) err = 1'b1;
`endif
    base = ((addr % NBYTES) / TL_DBW) * TL_DBW;
    if (!err && put)
      for (int l = 0; l < TL_DBW; l++)
        if (a_mask[l]) mbytes[base + l] = a_data[8*l +: 8];
    m_data = '0;
    if (!err && get)
      for (int l = 0; l < TL_DBW; l++) m_data[8*l +: 8] = mbytes[base + l];
    m_op     = get ? 3'd1 : 3'd0;
    m_err    = err;
    m_size   = a_size;
    m_src    = a_source;
    m_dvalid = 1'b1;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) m_dvalid = 1'b0;
    else if (a_valid && (!m_dvalid || d_ready)) model_accept();
    else if (d_ready) m_dvalid = 1'b0;
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("a_ready", 64'(a_ready), 64'(!rst && (!m_dvalid || d_ready)));
      chk("d_valid", 64'(d_valid), 64'(m_dvalid));
      if (rst) begin
        chk("rst_d_opcode", 64'(d_opcode), 64'(0));
        chk("rst_d_data",   64'(d_data),   64'(0));
        chk("rst_d_error",  64'(d_error),  64'(0));
        chk("rst_d_size",   64'(d_size),   64'(0));
        chk("rst_d_source", 64'(d_source), 64'(0));
      end else if (m_dvalid) begin
        chk("d_opcode", 64'(d_opcode), 64'(m_op));
        chk("d_error",  64'(d_error),  64'(m_err));
        chk("d_data",   64'(d_data),   64'(m_data));
        chk("d_size",   64'(d_size),   64'(m_size));
        chk("d_source", 64'(d_source), 64'(m_src));
        chk("d_param",  64'(d_param),  64'(0));
        chk("d_sink",   64'(d_sink),   64'(0));
      end
      if (d_valid && d_ready) consumed++;
    end
  end

  // Drives one beat from posedge+1 and returns at posedge+1 after it was accepted; a_valid stays high.
  task automatic send(input logic [2:0] op, input logic [1:0] sz, input logic [7:0] src,
                      input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data,
                      output int waited);
    bit ok = 1'b0;
    a_valid = 1'b1; a_opcode = op; a_param = '0; a_size = sz;
    a_source = src; a_address = addr; a_mask = mask; a_data = data;
    waited = 0;
    while (!ok && waited < 50) begin
      @(negedge clk);
      ok = a_ready;
      @(posedge clk);
      #1;
      waited++;
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: got no accept after %0d cycles, expected accept", waited);
    end
  endtask

  task automatic xact(input string nm, input logic [2:0] op, input logic [1:0] sz,
                      input logic [7:0] src, input logic [31:0] addr, input logic [3:0] mask,
                      input logic [31:0] data, input logic [2:0] e_op, input logic e_err,
                      input logic [31:0] e_data);
    int w;
    send(op, sz, src, addr, mask, data, w);
    a_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_valid"},  64'(d_valid),  64'(1));
    chk({nm, "_opcode"}, 64'(d_opcode), 64'(e_op));
    chk({nm, "_error"},  64'(d_error),  64'(e_err));
    chk({nm, "_data"},   64'(d_data),   64'(e_data));
    chk({nm, "_source"}, 64'(d_source), 64'(src));
    chk({nm, "_model"},  64'(m_data),   64'(e_data));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int w, total, c0;
    logic [31:0] wd0;
    #1 rst = 1'b1;
    #1 check_en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_d_valid", 64'(d_valid), 64'(0));
    chk("reset_a_ready", 64'(a_ready), 64'(0));
    @(posedge clk);
    #1 rst = 1'b0;

    // Give every word a known value.
    for (int i = 0; i < DEPTH; i++)
      send(3'd0, 2'd2, 8'(i), 32'(i * 4), 4'hF, 32'hA500_0000 | 32'(i), w);
    a_valid = 1'b0;
    @(posedge clk);
    #1;

    xact("putfull",  3'd0, 2'd2, 8'h5A, 32'h10, 4'hF, 32'h1122_3344, 3'd0, 1'b0, 32'h0);
    xact("get10",    3'd4, 2'd2, 8'h01, 32'h10, 4'hF, 32'h0,         3'd1, 1'b0, 32'h1122_3344);
    xact("putpart",  3'd1, 2'd1, 8'h02, 32'h12, 4'hC, 32'hBEEF_0000, 3'd0, 1'b0, 32'h0);
    xact("get10b",   3'd4, 2'd2, 8'h03, 32'h10, 4'hF, 32'h0,         3'd1, 1'b0, 32'hBEEF_3344);
    xact("misalign", 3'd4, 2'd1, 8'h04, 32'h11, 4'h6, 32'h0,         3'd1, 1'b1, 32'h0);
    xact("badop",    3'd2, 2'd2, 8'h05, 32'h10, 4'hF, 32'h0,         3'd0, 1'b1, 32'h0);
    xact("bigsize",  3'd4, 2'd3, 8'h06, 32'h10, 4'hF, 32'h0,         3'd1, 1'b1, 32'h0);
    xact("fullmask", 3'd0, 2'd2, 8'h07, 32'h10, 4'h7, 32'h0,         3'd0, 1'b1, 32'h0);
    xact("get10c",   3'd4, 2'd2, 8'h08, 32'h10, 4'hF, 32'h0,         3'd1, 1'b0, 32'hBEEF_3344);
    xact("getbyte",  3'd4, 2'd0, 8'h09, 32'h13, 4'h8, 32'h0,         3'd1, 1'b0, 32'hBEEF_3344);

`ifdef TL_RAM_BOUNDS_CHECK_EN
    xact("oob_put",  3'd0, 2'd2, 8'h33, 32'h400, 4'hF, 32'hDEAD_BEEF, 3'd0, 1'b1, 32'h0);
    wd0 = 32'hA500_0000;
`else
    xact("oob_put",  3'd0, 2'd2, 8'h33, 32'h400, 4'hF, 32'hDEAD_BEEF, 3'd0, 1'b0, 32'h0);
    wd0 = 32'hDEAD_BEEF;
`endif
    xact("get0",     3'd4, 2'd2, 8'h34, 32'h0, 4'hF, 32'h0, 3'd1, 1'b0, wd0);

    // Reset while a response is stalled; the accepted write must persist.
    d_ready = 1'b0;
    send(3'd0, 2'd2, 8'h40, 32'h20, 4'hF, 32'hCAFE_F00D, w);
    a_valid = 1'b0;
    @(negedge clk);
    #1 chk("pre_rst_d_valid", 64'(d_valid), 64'(1));
    rst = 1'b1;
    #1 chk("rst_drop_d_valid", 64'(d_valid), 64'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    d_ready = 1'b1;
    xact("get20",    3'd4, 2'd2, 8'h41, 32'h20, 4'hF, 32'h0, 3'd1, 1'b0, 32'hCAFE_F00D);

    // Back-pressure with a held request, then 8 back-to-back Gets.
    d_ready = 1'b0;
    send(3'd4, 2'd2, 8'h50, 32'h10, 4'hF, 32'h0, w);
    a_valid = 1'b1; a_address = 32'h0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_a_ready", 64'(a_ready), 64'(0));
      chk("bp_d_data",  64'(d_data),  64'(32'hBEEF_3344));
      chk("bp_d_source", 64'(d_source), 64'(8'h50));
    end
    @(posedge clk);
    #1 d_ready = 1'b1;
    c0 = consumed;
    total = 0;
    for (int k = 0; k < 8; k++) begin
      send(3'd4, 2'd2, 8'(8'h60 + k), 32'(k * 4), 4'hF, 32'h0, w);
      total += w;
    end
    a_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("burst_accept_cycles", 64'(total), 64'(8));
    chk("burst_responses", 64'(consumed - c0), 64'(9));
    @(posedge clk);
    #1;

    // Randomised traffic.
    for (int c = 0; c < 3000; c++) begin
      int unsigned r, sz, word, off, addr, em;
      d_ready = ($urandom_range(0, 3) != 0);
      a_valid = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 15);
      a_opcode = (r < 5) ? 3'd0 : (r < 10) ? 3'd1 : (r < 15) ? 3'd4 : 3'($urandom_range(0, 7));
      a_param = ($urandom_range(0, 31) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      sz = ($urandom_range(0, 15) == 0) ? 3 : $urandom_range(0, 2);
      a_size = 2'(sz);
      word = $urandom_range(0, DEPTH - 1);
      off = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 3) : (($urandom_range(0, 3) >> sz) << sz);
      addr = word * 4 + off;
      if ($urandom_range(0, 15) == 0) addr = addr | ($urandom_range(1, 255) << 10);
      a_address = addr;
      em = ((1 << (1 << sz)) - 1) << off;
      if ($urandom_range(0, 7) == 0) a_mask = 4'($urandom_range(0, 15));
      else if (a_opcode == 3'd1) a_mask = 4'(em & $urandom_range(1, 15));
      else a_mask = 4'(em);
      a_source = 8'($urandom_range(0, 255));
      a_data = $urandom;
      @(posedge clk);
      #1;
    end
    a_valid = 1'b0;
    d_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
